// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It inhibits the bus and issues a start bit.
// It then shifts one byte plus odd parity on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       k_clk,
    input  logic       k_data,
    output logic       k_clk_oe,
    output logic       k_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_BITS    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t           state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
    logic             data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic             k_clk_oe_q, k_clk_oe_d, k_data_oe_q, k_data_oe_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic             fall_evt;
    logic             timeout_hit;

    assign fall_evt    = clk_prev_q & ~clk_sync_q;
    assign timeout_hit = ((state_q == ST_REQ) || (state_q == ST_BITS) ||
                          (state_q == ST_ACK) || (state_q == ST_RELEASE)) &&
                         (to_cnt_q == TO_LAST);

    // Next-state, datapath and registered-output computation
    always_comb begin
        clk_meta_d  = k_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = k_data;
        data_sync_d = data_meta_q;
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        k_clk_oe_d  = k_clk_oe_q;
        k_data_oe_d = k_data_oe_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        if (timeout_hit) begin
            state_d     = ST_IDLE;
            k_clk_oe_d  = 1'b0;
            k_data_oe_d = 1'b0;
            error_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    k_clk_oe_d  = 1'b0;
                    k_data_oe_d = 1'b0;
                    bit_cnt_d   = 4'd0;
                    inh_cnt_d   = '0;
                    to_cnt_d    = '0;
                    if (tx_start) begin
                        shift_d    = {odd_parity(tx_data), tx_data};
                        k_clk_oe_d = 1'b1;
                        state_d    = ST_INHIBIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                // Falls seen here are our own k_clk pull-down and are ignored.
                ST_INHIBIT: begin
                    if (inh_cnt_q == INH_LAST) begin
                        k_clk_oe_d  = 1'b0;
                        k_data_oe_d = 1'b1;
                        bit_cnt_d   = 4'd0;
                        to_cnt_d    = '0;
                        state_d     = ST_REQ;
                    end else begin
                        inh_cnt_d = inh_cnt_q + 1'b1;
                    end
                end
                ST_REQ, ST_BITS: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall_evt) begin
                        to_cnt_d = '0;
                        if (bit_cnt_q < 4'd9) begin
                            k_data_oe_d = ~shift_q[bit_cnt_q];
                            bit_cnt_d   = bit_cnt_q + 4'd1;
                            state_d     = ST_BITS;
                        end else begin
                            k_data_oe_d = 1'b0;
                            state_d     = ST_ACK;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ACK: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (fall_evt) begin
                        to_cnt_d = '0;
                        if (!data_sync_q) begin
                            state_d = ST_RELEASE;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_RELEASE: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (clk_sync_q && data_sync_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    k_clk_oe_d  = 1'b0;
                    k_data_oe_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, synchronisers and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= 9'd0;
            bit_cnt_q   <= 4'd0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            k_clk_oe_q  <= 1'b0;
            k_data_oe_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            k_clk_oe_q  <= k_clk_oe_d;
            k_data_oe_q <= k_data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign k_clk_oe  = k_clk_oe_q;
    assign k_data_oe = k_data_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain bus with a cycle-based keyboard model.
// Expected frames are hand-computed as {stop, parity, data[7:0], start}.
module tb_ps2_host_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    logic        k_clk_line, k_data_line;
    logic        k_clk_oe, k_data_oe, busy, done, error;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = 8'd0;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_total = 0, err_total = 0, both_total = 0, edge_bad = 0, clk_oe_total = 0;
    logic prev_busy = 1'b0;

    logic [10:0] frame;
    int          last_fall;
    int          d0, e0, c0, t;

    assign k_clk_line  = ~(k_clk_oe | dev_clk_low);
    assign k_data_line = ~(k_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
        .clk(clk), .rst(rst), .k_clk(k_clk_line), .k_data(k_data_line),
        .k_clk_oe(k_clk_oe), .k_data_oe(k_data_oe), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and line-activity monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (done) done_total <= done_total + 1;
        if (error) err_total <= err_total + 1;
        if (done && error) both_total <= both_total + 1;
        if ((done || error) && !(prev_busy && !busy)) edge_bad <= edge_bad + 1;
        if (k_clk_oe) clk_oe_total <= clk_oe_total + 1;
        prev_busy <= busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Keyboard: samples data while clock is high, just before each fall.
    task automatic device_xfer(input int n_pulses, input logic ack,
                               output logic [10:0] fr, output int lf);
        int w;
        fr = 11'd0;
        lf = 0;
        w  = 0;
        while (!(k_clk_line && !k_data_line) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("req_seen", (w < 1000) ? 32'd1 : 32'd0, 32'd1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < n_pulses; i++) begin
            fr[4'(i)] = k_data_line;
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            lf = cyc;
            repeat (20) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_idle"}, (w < 2000) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic full_xfer(input string tag, input logic [7:0] b, input logic [10:0] exp_frame);
        int dd, ee, cc;
        logic [10:0] fr;
        int lf;
        dd = done_total;
        ee = err_total;
        cc = clk_oe_total;
        send(b);
        device_xfer(11, 1'b1, fr, lf);
        wait_idle(tag);
        check({tag, "_frame"}, 32'(fr), 32'(exp_frame));
        check({tag, "_done"}, 32'(done_total - dd), 32'd1);
        check({tag, "_err"}, 32'(err_total - ee), 32'd0);
        check({tag, "_inhibit"}, 32'(clk_oe_total - cc), 32'd20);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(k_clk_oe), 32'd0);
        check("rst_data_oe", 32'(k_data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, error}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1
        full_xfer("ed", 8'hED, 11'h7DA);
        full_xfer("x01", 8'h01, 11'h402);
        full_xfer("x00", 8'h00, 11'h600);

        // Device never ACKs
        d0 = done_total; e0 = err_total;
        send(8'hED);
        device_xfer(11, 1'b0, frame, last_fall);
        wait_idle("nack");
        check("nack_frame", 32'(frame), 32'h7DA);
        check("nack_err", 32'(err_total - e0), 32'd1);
        check("nack_done", 32'(done_total - d0), 32'd0);
        check("nack_oe", 32'({k_clk_oe, k_data_oe}), 32'd0);
        check("nack_busy", 32'(busy), 32'd0);

        // Device stops after the fall that sends bit 3; fall processed 3 edges after drive
        d0 = done_total; e0 = err_total;
        send(8'hED);
        device_xfer(4, 1'b0, frame, last_fall);
        t = 0;
        while (!error && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("to_seen", (t < 1000) ? 32'd1 : 32'd0, 32'd1);
        check("to_latency", 32'(cyc - last_fall), 32'd503);
        check("to_oe", 32'({k_clk_oe, k_data_oe}), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("to_err", 32'(err_total - e0), 32'd1);
        check("to_done", 32'(done_total - d0), 32'd0);

        // Reset in BITS after bit 5 of 0x00 (data line held low)
        d0 = done_total; e0 = err_total;
        send(8'h00);
        device_xfer(6, 1'b0, frame, last_fall);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_data_oe", 32'(k_data_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", 32'({k_clk_oe, k_data_oe}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_pulses", 32'((done_total - d0) + (err_total - e0)), 32'd0);
        full_xfer("xff", 8'hFF, 11'h7FE);

        // tx_start with 0x55 while busy (once in INHIBIT, once in BITS) is ignored
        d0 = done_total; e0 = err_total; c0 = clk_oe_total;
        send(8'h01);
        fork
            device_xfer(11, 1'b1, frame, last_fall);
            begin
                repeat (5) @(negedge clk);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (150) @(negedge clk);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        wait_idle("busy_ign");
        repeat (100) @(negedge clk);
        check("busy_ign_frame", 32'(frame), 32'h402);
        check("busy_ign_done", 32'(done_total - d0), 32'd1);
        check("busy_ign_err", 32'(err_total - e0), 32'd0);
        check("busy_ign_inhibit", 32'(clk_oe_total - c0), 32'd20);
        check("busy_ign_idle", 32'(busy), 32'd0);

        check("done_err_overlap", 32'(both_total), 32'd0);
        check("busy_drop_edge", 32'(edge_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
